fetch_unit: RTL and testbench
=============================

# fetch_unit

Parametrised instruction-fetch front end: owns the program counter, issues in-order requests to instruction memory, and buffers returned instructions with their PCs in a DEPTH-entry queue feeding decode through a valid/ready handshake. It sits between the PC-redirect sources (exception, branch, jump, hazard stall) and the decode stage. Redirects flush the queue and discard responses still in flight.

## Interface
- ADDR_SIZE, 32: PC / memory address width.
- INSTR_SIZE, 32: instruction width.
- DEPTH, 4: queue entries; power of two, ≥2.
- RESET_PC, 32'h0000_1000: PC value after reset.
- EXC_VECTOR, 32'h0000_2000: PC loaded on exception.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- is_exception  in  1  redirect to EXC_VECTOR.
- is_branch  in  1  redirect to pc_branch.
- pc_branch  in  ADDR_SIZE  branch target.
- is_jump  in  1  redirect to pc_jump.
- pc_jump  in  ADDR_SIZE  jump target.
- pc_write  in  1  0 = hold PC, issue no request (hazard stall).
- imem_req_valid  out  1  request valid.
- imem_req_addr  out  ADDR_SIZE  request address (current PC).
- imem_req_ready  in  1  memory accepts request.
- imem_resp_valid  in  1  response valid; responses return in request order, no backpressure.
- imem_resp_data  in  INSTR_SIZE  instruction word.
- out_valid  out  1  queue head valid.
- out_pc  out  ADDR_SIZE  PC of head instruction.
- out_instr  out  INSTR_SIZE  head instruction.
- out_ready  in  1  decode accepts head.

## Operation
- PC register; next PC priority: reset > is_exception (EXC_VECTOR) > is_branch (pc_branch) > is_jump (pc_jump) > request accepted (PC+4, wraps modulo 2^ADDR_SIZE) > hold.
- Redirects apply regardless of pc_write.
- imem_req_valid = !reset && pc_write && no redirect this cycle && (outstanding + occupancy) < DEPTH; imem_req_addr = PC.
- Accepted request pushes its PC into a pending-PC FIFO (depth DEPTH); outstanding += 1.
- Response with discard_cnt = 0: pair with pending-PC head, write {pc, instr} into queue; outstanding -= 1. Credit check guarantees queue never overflows.
- Response with discard_cnt > 0: dropped, discard_cnt -= 1.
- Redirect: queue and pending-PC FIFO cleared; discard_cnt <= outstanding + discard_cnt − (response arriving this cycle ? 1 : 0); outstanding <= 0.
- Pop when out_valid && out_ready. Pop coinciding with redirect: handshake completes, queue still flushed (decode kills that instruction itself).
- Push and pop in the same cycle: occupancy unchanged.
- Counters sized $clog2(DEPTH+1) bits.

## Timing
- Reset: PC = RESET_PC, queue empty, outstanding = discard_cnt = 0; imem_req_valid = 0, out_valid = 0, out_pc = 0, out_instr = 0.
- First request on first cycle after reset deasserts.
- Redirect in cycle N: new PC visible on imem_req_addr in N+1; no request in N.
- Response in cycle N → out_valid in N+1 if queue was empty (one-cycle latency).
- Full (outstanding + occupancy = DEPTH): imem_req_valid low until a pop.
- Reset mid-operation: all state cleared; responses to pre-reset requests must not arrive after reset (memory is reset together).

## Configuration
- FETCH_PERF_EN defined: adds outputs perf_redirects (32 bits, counts redirect cycles) and perf_stall_cycles (32 bits, cycles with pc_write = 1 and imem_req_valid = 0 or !imem_req_ready); both cleared by reset, wrap on overflow.
- Undefined: ports and counters absent; behaviour otherwise identical.

## Structure
- Shared header define.v: ADDR_SIZE, INSTR_SIZE defaults, RESET_PC, EXC_VECTOR, PC increment constant 4.
- One sub-module: fetch_fifo (parametrised width/depth, synchronous flush, push/pop, full/empty/count), instantiated twice: pending-PC FIFO and instruction queue.

## Test plan
- Reset release, imem_req_ready = 1, 1-cycle memory, out_ready = 1 → addrs 0x1000, 0x1004, 0x1008…; outputs pair matching PC/instr in order.
- out_ready = 0 with DEPTH = 4 → exactly 4 requests issued, then imem_req_valid = 0; raising out_ready resumes at 0x1010.
- is_branch = 1, pc_branch = 0x4000 with 2 responses in flight → both dropped, queue empty next cycle, next request 0x4000, first output pc 0x4000.
- is_exception, is_branch and is_jump together → next request 0x2000.
- pc_write = 0 for 3 cycles → no requests, PC held; queue still drains to decode.
- PC = 0xFFFF_FFFC accepted → next request 0x0000_0000.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared constants and types for the instruction fetch front end
//
// Purpose : default widths, reset/exception PCs, PC increment and the
//           redirect-source encoding used by fetch_unit.
// Ports   : none (package).
// Config  : none.
package fetch_unit_pkg;

  localparam int          DEF_ADDR_SIZE  = 32;
  localparam int          DEF_INSTR_SIZE = 32;
  localparam logic [31:0] DEF_RESET_PC   = 32'h0000_1000;
  localparam logic [31:0] DEF_EXC_VECTOR = 32'h0000_2000;
  localparam int          PC_INC         = 4;

  typedef enum logic [1:0] {
    REDIR_NONE   = 2'd0,
    REDIR_EXC    = 2'd1,
    REDIR_BRANCH = 2'd2,
    REDIR_JUMP   = 2'd3
  } redirect_e;

  // Exception outranks branch, branch outranks jump.
  function automatic redirect_e redirect_sel(input logic exc, input logic br, input logic jmp);
    if (exc)      return REDIR_EXC;
    else if (br)  return REDIR_BRANCH;
    else if (jmp) return REDIR_JUMP;
    else          return REDIR_NONE;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction-memory and decode-side handshake bundle
//
// Purpose : groups the imem request/response channel and the decode output
//           channel of fetch_unit.
// Signals : imem_req_valid/addr/ready, imem_resp_valid/data,
//           out_valid/pc/instr/ready.
// Modports: master = fetch_unit side, slave = memory + decode side.
// Config  : none.
interface fetch_unit_if
  import fetch_unit_pkg::*;
#(
  parameter int ADDR_SIZE  = DEF_ADDR_SIZE,
  parameter int INSTR_SIZE = DEF_INSTR_SIZE
) ();

  logic                  imem_req_valid;
  logic [ADDR_SIZE-1:0]  imem_req_addr;
  logic                  imem_req_ready;
  logic                  imem_resp_valid;
  logic [INSTR_SIZE-1:0] imem_resp_data;
  logic                  out_valid;
  logic [ADDR_SIZE-1:0]  out_pc;
  logic [INSTR_SIZE-1:0] out_instr;
  logic                  out_ready;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready,
    input  imem_resp_valid, imem_resp_data,
    output out_valid, out_pc, out_instr,
    input  out_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready,
    output imem_resp_valid, imem_resp_data,
    input  out_valid, out_pc, out_instr,
    output out_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - small synchronous FIFO with flush, used for pending PCs and the fetch queue
//
// Purpose : WIDTH x DEPTH circular buffer (DEPTH power of two, >= 2).
// Ports   : clk, reset (sync, active-high), flush (sync clear),
//           push/wdata, pop/rdata, full, empty, count.
// Notes   : rdata reads as zero while empty; flush beats push and pop.
// Config  : none.
module fetch_fifo #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = empty ? '0 : mem_q[rptr_q];

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + AW'(1);
      if (do_pop)  rptr_d = rptr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: contents are only visible through count/empty.
  always_ff @(posedge clk) begin
    if (do_push && !flush && !reset) mem_q[wptr_q] <= wdata;
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch front end: PC, in-order imem requests, fetch queue to decode
//
// Purpose : owns the PC, issues one request per accepted cycle, pairs
//           in-order responses with their PCs and buffers them in a
//           DEPTH-entry queue; redirects flush and drop in-flight responses.
// Ports   : clk, reset (sync, active-high), is_exception, is_branch/pc_branch,
//           is_jump/pc_jump, pc_write, bus (fetch_unit_if.master).
//           With FETCH_PERF_EN: perf_redirects, perf_stall_cycles.
// Config  : FETCH_PERF_EN adds redirect and stall performance counters.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                   ADDR_SIZE  = DEF_ADDR_SIZE,
  parameter int                   INSTR_SIZE = DEF_INSTR_SIZE,
  parameter int                   DEPTH      = 4,
  parameter logic [ADDR_SIZE-1:0] RESET_PC   = ADDR_SIZE'(DEF_RESET_PC),
  parameter logic [ADDR_SIZE-1:0] EXC_VECTOR = ADDR_SIZE'(DEF_EXC_VECTOR)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 is_exception,
  input  logic                 is_branch,
  input  logic [ADDR_SIZE-1:0] pc_branch,
  input  logic                 is_jump,
  input  logic [ADDR_SIZE-1:0] pc_jump,
  input  logic                 pc_write,
  fetch_unit_if.master         bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]          perf_redirects,
  output logic [31:0]          perf_stall_cycles
`endif
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int QW = ADDR_SIZE + INSTR_SIZE;

  logic [ADDR_SIZE-1:0] pc_q, pc_d;
  logic [CW-1:0]        discard_q, discard_d;

  redirect_e            redir;
  logic                 redirect;
  logic [CW:0]          inflight;
  logic                 credit_ok;
  logic                 req_valid, req_fire;
  logic                 resp_keep, resp_drop;
  logic                 q_pop;

  logic [ADDR_SIZE-1:0] pend_rdata;
  logic                 pend_full, pend_empty;
  logic [CW-1:0]        pend_count;
  logic [QW-1:0]        q_rdata;
  logic                 q_full, q_empty;
  logic [CW-1:0]        q_count;

  assign redir    = redirect_sel(is_exception, is_branch, is_jump);
  assign redirect = (redir != REDIR_NONE);

  // The pending-PC FIFO holds exactly the requests whose responses will be
  // kept, so its occupancy is the outstanding count. Reserving a queue slot
  // for every outstanding request guarantees the queue never overflows.
  assign inflight  = {1'b0, pend_count} + {1'b0, q_count};
  assign credit_ok = (inflight < (CW+1)'(DEPTH));
  assign req_valid = !reset && pc_write && !redirect && credit_ok;
  assign req_fire  = req_valid && bus.imem_req_ready;

  // Responses belonging to requests issued before a redirect come back
  // first (in-order memory) and are swallowed while discard_q is non-zero.
  assign resp_drop = bus.imem_resp_valid && (discard_q != '0);
  assign resp_keep = bus.imem_resp_valid && (discard_q == '0) && !pend_empty;
  assign q_pop     = !q_empty && bus.out_ready;

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = pc_q;
  assign bus.out_valid      = !q_empty;
  assign bus.out_pc         = q_rdata[QW-1:INSTR_SIZE];
  assign bus.out_instr      = q_rdata[INSTR_SIZE-1:0];

  always_comb begin
    pc_d = pc_q;
    case (redir)
      REDIR_EXC:    pc_d = EXC_VECTOR;
      REDIR_BRANCH: pc_d = pc_branch;
      REDIR_JUMP:   pc_d = pc_jump;
      default:      if (req_fire) pc_d = pc_q + ADDR_SIZE'(PC_INC);
    endcase
  end

  always_comb begin
    discard_d = discard_q;
    if (redirect) begin
      // Everything still in flight becomes garbage; a response landing this
      // very cycle is already gone (dropped or flushed), so it is not counted.
      discard_d = discard_q + pend_count - CW'(bus.imem_resp_valid);
    end else if (resp_drop) begin
      discard_d = discard_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q      <= RESET_PC;
      discard_q <= '0;
    end else begin
      pc_q      <= pc_d;
      discard_q <= discard_d;
    end
  end

  fetch_fifo #(.WIDTH(ADDR_SIZE), .DEPTH(DEPTH)) u_pend_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (redirect),
    .push  (req_fire && !pend_full),
    .wdata (pc_q),
    .pop   (resp_keep),
    .rdata (pend_rdata),
    .full  (pend_full),
    .empty (pend_empty),
    .count (pend_count)
  );

  fetch_fifo #(.WIDTH(QW), .DEPTH(DEPTH)) u_instr_queue (
    .clk   (clk),
    .reset (reset),
    .flush (redirect),
    .push  (resp_keep && !q_full),
    .wdata ({pend_rdata, bus.imem_resp_data}),
    .pop   (q_pop),
    .rdata (q_rdata),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count)
  );

`ifdef FETCH_PERF_EN
  logic [31:0] perf_redirects_q, perf_redirects_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_redirects_d = perf_redirects_q + 32'(redirect);
    perf_stall_d     = perf_stall_q + 32'(pc_write && (!req_valid || !bus.imem_req_ready));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_redirects_q <= '0;
      perf_stall_q     <= '0;
    end else begin
      perf_redirects_q <= perf_redirects_d;
      perf_stall_q     <= perf_stall_d;
    end
  end

  assign perf_redirects    = perf_redirects_q;
  assign perf_stall_cycles = perf_stall_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
//
// Purpose : drives redirect/stall inputs, models an in-order instruction
//           memory (configurable latency, instr = ~addr) and logs issued
//           requests and decode handshakes for comparison.
// Config  : FETCH_PERF_EN connects the performance counter outputs.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        is_exception, is_branch, is_jump, pc_write;
  logic [31:0] pc_branch, pc_jump;

  always #5 clk = ~clk;

  fetch_unit_if #(.ADDR_SIZE(32), .INSTR_SIZE(32)) bus ();

`ifdef FETCH_PERF_EN
  logic [31:0] perf_redirects, perf_stall_cycles;
`endif

  fetch_unit #(
    .ADDR_SIZE (32),
    .INSTR_SIZE(32),
    .DEPTH     (4),
    .RESET_PC  (32'h0000_1000),
    .EXC_VECTOR(32'h0000_2000)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .is_exception(is_exception),
    .is_branch   (is_branch),
    .pc_branch   (pc_branch),
    .is_jump     (is_jump),
    .pc_jump     (pc_jump),
    .pc_write    (pc_write),
    .bus         (bus)
`ifdef FETCH_PERF_EN
    ,
    .perf_redirects   (perf_redirects),
    .perf_stall_cycles(perf_stall_cycles)
`endif
  );

  int tests_run    = 0;
  int tests_failed = 0;
  int mem_lat      = 1;
  int neg_n        = 0;

  int          due_q[$];
  logic [31:0] addr_q[$];
  logic [31:0] req_log[$];
  logic [31:0] got_pc[$];
  logic [31:0] got_instr[$];

  // Memory and monitor act on the falling edge, half a cycle away from the
  // DUT's sampling edge; inputs are stable by then.
  always @(negedge clk) begin
    neg_n++;
    if (reset) begin
      due_q.delete();
      addr_q.delete();
      bus.imem_resp_valid = 1'b0;
      bus.imem_resp_data  = '0;
    end else begin
      if (due_q.size() > 0 && due_q[0] == neg_n) begin
        bus.imem_resp_valid = 1'b1;
        bus.imem_resp_data  = ~addr_q[0];
        void'(due_q.pop_front());
        void'(addr_q.pop_front());
      end else begin
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = '0;
      end
      if (bus.imem_req_valid && bus.imem_req_ready) begin
        due_q.push_back(neg_n + mem_lat);
        addr_q.push_back(bus.imem_req_addr);
        req_log.push_back(bus.imem_req_addr);
      end
      if (bus.out_valid && bus.out_ready) begin
        got_pc.push_back(bus.out_pc);
        got_instr.push_back(bus.out_instr);
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    req_log.delete();
    got_pc.delete();
    got_instr.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1; is_exception = 1'b0; is_branch = 1'b0; is_jump = 1'b0;
    pc_branch = '0; pc_jump = '0; pc_write = 1'b1;
    bus.imem_req_ready = 1'b1; bus.out_ready = 1'b1; mem_lat = 1;
    cycle(); cycle();
    tests_run++; if (bus.imem_req_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_req_valid: got %b want 0", bus.imem_req_valid); end
    tests_run++; if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    tests_run++; if (bus.out_pc !== 32'h0) begin tests_failed++; $display("FAIL reset_out_pc: got %h want 0", bus.out_pc); end
    tests_run++; if (bus.out_instr !== 32'h0) begin tests_failed++; $display("FAIL reset_out_instr: got %h want 0", bus.out_instr); end
    reset = 1'b0;
    clear_logs();
    #1;
    tests_run++; if (bus.imem_req_valid !== 1'b1) begin tests_failed++; $display("FAIL first_req_valid: got %b want 1", bus.imem_req_valid); end
    tests_run++; if (bus.imem_req_addr !== 32'h1000) begin tests_failed++; $display("FAIL first_req_addr: got %h want 00001000", bus.imem_req_addr); end
  endtask

  task automatic test_stream();
    logic [31:0] v;
    cycle(); cycle();
    tests_run++; if (bus.out_valid !== 1'b1) begin tests_failed++; $display("FAIL stream_latency_valid: got %b want 1", bus.out_valid); end
    tests_run++; if (bus.out_pc !== 32'h1000) begin tests_failed++; $display("FAIL stream_latency_pc: got %h want 00001000", bus.out_pc); end
    tests_run++; if (bus.out_instr !== 32'hFFFF_EFFF) begin tests_failed++; $display("FAIL stream_latency_instr: got %h want ffffefff", bus.out_instr); end
    repeat (6) cycle();
    pc_write = 1'b0;
    repeat (4) cycle();
    tests_run++; if (req_log.size() !== 8) begin tests_failed++; $display("FAIL stream_req_count: got %0d want 8", req_log.size()); end
    tests_run++; if (got_pc.size() !== 8) begin tests_failed++; $display("FAIL stream_out_count: got %0d want 8", got_pc.size()); end
    for (int i = 0; i < 8; i++) begin
      v = (i < req_log.size()) ? req_log[i] : 'x;
      tests_run++; if (v !== 32'h1000 + 32'(4*i)) begin tests_failed++; $display("FAIL stream_req_addr[%0d]: got %h want %h", i, v, 32'h1000 + 32'(4*i)); end
      v = (i < got_pc.size()) ? got_pc[i] : 'x;
      tests_run++; if (v !== 32'h1000 + 32'(4*i)) begin tests_failed++; $display("FAIL stream_out_pc[%0d]: got %h want %h", i, v, 32'h1000 + 32'(4*i)); end
      v = (i < got_instr.size()) ? got_instr[i] : 'x;
      tests_run++; if (v !== ~(32'h1000 + 32'(4*i))) begin tests_failed++; $display("FAIL stream_out_instr[%0d]: got %h want %h", i, v, ~(32'h1000 + 32'(4*i))); end
    end
  endtask

  task automatic test_full();
    logic [31:0] v;
    clear_logs();
    bus.out_ready = 1'b0;
    pc_write = 1'b1;
    repeat (6) cycle();
    tests_run++; if (req_log.size() !== 4) begin tests_failed++; $display("FAIL full_req_count: got %0d want 4", req_log.size()); end
    tests_run++; if (bus.imem_req_valid !== 1'b0) begin tests_failed++; $display("FAIL full_req_valid: got %b want 0", bus.imem_req_valid); end
    tests_run++; if (bus.out_pc !== 32'h1020) begin tests_failed++; $display("FAIL full_head_pc: got %h want 00001020", bus.out_pc); end
    bus.out_ready = 1'b1;
    #1;
    tests_run++; if (bus.imem_req_valid !== 1'b0) begin tests_failed++; $display("FAIL full_until_pop: got %b want 0", bus.imem_req_valid); end
    cycle();
    tests_run++; if (bus.imem_req_valid !== 1'b1) begin tests_failed++; $display("FAIL full_resume_valid: got %b want 1", bus.imem_req_valid); end
    tests_run++; if (bus.imem_req_addr !== 32'h1030) begin tests_failed++; $display("FAIL full_resume_addr: got %h want 00001030", bus.imem_req_addr); end
    cycle();
    pc_write = 1'b0;
    repeat (6) cycle();
    tests_run++; if (got_pc.size() !== 5) begin tests_failed++; $display("FAIL full_out_count: got %0d want 5", got_pc.size()); end
    for (int i = 0; i < 5; i++) begin
      v = (i < got_pc.size()) ? got_pc[i] : 'x;
      tests_run++; if (v !== 32'h1020 + 32'(4*i)) begin tests_failed++; $display("FAIL full_out_pc[%0d]: got %h want %h", i, v, 32'h1020 + 32'(4*i)); end
    end
  endtask

  task automatic test_branch_flush();
    logic [31:0] v;
    clear_logs();
    mem_lat = 2;
    pc_write = 1'b1;
    cycle(); cycle();
    is_branch = 1'b1; pc_branch = 32'h4000;
    #1;
    tests_run++; if (bus.imem_req_valid !== 1'b0) begin tests_failed++; $display("FAIL branch_no_req: got %b want 0", bus.imem_req_valid); end
    cycle();
    is_branch = 1'b0;
    #1;
    tests_run++; if (bus.imem_req_addr !== 32'h4000) begin tests_failed++; $display("FAIL branch_target_addr: got %h want 00004000", bus.imem_req_addr); end
    tests_run++; if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL branch_flush_empty: got %b want 0", bus.out_valid); end
    cycle();
    tests_run++; if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL branch_discard_empty: got %b want 0", bus.out_valid); end
    cycle(); cycle();
    pc_write = 1'b0;
    repeat (8) cycle();
    tests_run++; if (req_log.size() !== 5) begin tests_failed++; $display("FAIL branch_req_count: got %0d want 5", req_log.size()); end
    tests_run++; if (got_pc.size() !== 3) begin tests_failed++; $display("FAIL branch_out_count: got %0d want 3", got_pc.size()); end
    for (int i = 0; i < 3; i++) begin
      v = (i < got_pc.size()) ? got_pc[i] : 'x;
      tests_run++; if (v !== 32'h4000 + 32'(4*i)) begin tests_failed++; $display("FAIL branch_out_pc[%0d]: got %h want %h", i, v, 32'h4000 + 32'(4*i)); end
      v = (i < got_instr.size()) ? got_instr[i] : 'x;
      tests_run++; if (v !== ~(32'h4000 + 32'(4*i))) begin tests_failed++; $display("FAIL branch_out_instr[%0d]: got %h want %h", i, v, ~(32'h4000 + 32'(4*i))); end
    end
    mem_lat = 1;
  endtask

  task automatic test_priority();
    clear_logs();
    pc_write = 1'b0;
    is_exception = 1'b1; is_branch = 1'b1; is_jump = 1'b1;
    pc_branch = 32'h5000; pc_jump = 32'h6000;
    cycle();
    is_exception = 1'b0;
    #1;
    tests_run++; if (bus.imem_req_addr !== 32'h2000) begin tests_failed++; $display("FAIL prio_exception: got %h want 00002000", bus.imem_req_addr); end
    cycle();
    is_branch = 1'b0;
    #1;
    tests_run++; if (bus.imem_req_addr !== 32'h5000) begin tests_failed++; $display("FAIL prio_branch: got %h want 00005000", bus.imem_req_addr); end
    cycle();
    pc_jump = 32'h7000; pc_write = 1'b1;
    #1;
    tests_run++; if (bus.imem_req_addr !== 32'h6000) begin tests_failed++; $display("FAIL prio_jump: got %h want 00006000", bus.imem_req_addr); end
    tests_run++; if (bus.imem_req_valid !== 1'b0) begin tests_failed++; $display("FAIL prio_redirect_blocks_req: got %b want 0", bus.imem_req_valid); end
    cycle();
    is_jump = 1'b0; pc_write = 1'b0;
    #1;
    tests_run++; if (bus.imem_req_addr !== 32'h7000) begin tests_failed++; $display("FAIL prio_jump_stalled: got %h want 00007000", bus.imem_req_addr); end
    tests_run++; if (req_log.size() !== 0) begin tests_failed++; $display("FAIL prio_req_count: got %0d want 0", req_log.size()); end
  endtask

  task automatic test_stall();
    logic [31:0] v;
    clear_logs();
    bus.out_ready = 1'b0;
    pc_write = 1'b1;
    cycle(); cycle(); cycle();
    pc_write = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests_run++; if (bus.imem_req_valid !== 1'b0) begin tests_failed++; $display("FAIL stall_req_valid[%0d]: got %b want 0", i, bus.imem_req_valid); end
      tests_run++; if (bus.imem_req_addr !== 32'h700C) begin tests_failed++; $display("FAIL stall_pc_hold[%0d]: got %h want 0000700c", i, bus.imem_req_addr); end
      cycle();
    end
    tests_run++; if (got_pc.size() !== 3) begin tests_failed++; $display("FAIL stall_drain_count: got %0d want 3", got_pc.size()); end
    for (int i = 0; i < 3; i++) begin
      v = (i < got_pc.size()) ? got_pc[i] : 'x;
      tests_run++; if (v !== 32'h7000 + 32'(4*i)) begin tests_failed++; $display("FAIL stall_out_pc[%0d]: got %h want %h", i, v, 32'h7000 + 32'(4*i)); end
    end
    tests_run++; if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL stall_drained: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_wrap();
    logic [31:0] v;
    clear_logs();
    pc_write = 1'b0;
    is_jump = 1'b1; pc_jump = 32'hFFFF_FFFC;
    cycle();
    is_jump = 1'b0; pc_write = 1'b1;
    #1;
    tests_run++; if (bus.imem_req_addr !== 32'hFFFF_FFFC) begin tests_failed++; $display("FAIL wrap_top_addr: got %h want fffffffc", bus.imem_req_addr); end
    cycle();
    tests_run++; if (bus.imem_req_addr !== 32'h0) begin tests_failed++; $display("FAIL wrap_zero_addr: got %h want 00000000", bus.imem_req_addr); end
    tests_run++; if (bus.imem_req_valid !== 1'b1) begin tests_failed++; $display("FAIL wrap_zero_valid: got %b want 1", bus.imem_req_valid); end
    cycle();
    pc_write = 1'b0;
    repeat (4) cycle();
    tests_run++; if (got_pc.size() !== 2) begin tests_failed++; $display("FAIL wrap_out_count: got %0d want 2", got_pc.size()); end
    v = (got_pc.size() > 1) ? got_pc[1] : 'x;
    tests_run++; if (v !== 32'h0) begin tests_failed++; $display("FAIL wrap_out_pc: got %h want 00000000", v); end
    v = (got_instr.size() > 1) ? got_instr[1] : 'x;
    tests_run++; if (v !== 32'hFFFF_FFFF) begin tests_failed++; $display("FAIL wrap_out_instr: got %h want ffffffff", v); end
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b0;
    pc_write = 1'b1;
    cycle(); cycle(); cycle();
    reset = 1'b1;
    cycle();
    tests_run++; if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL midreset_out_valid: got %b want 0", bus.out_valid); end
    tests_run++; if (bus.imem_req_valid !== 1'b0) begin tests_failed++; $display("FAIL midreset_req_valid: got %b want 0", bus.imem_req_valid); end
    reset = 1'b0;
    #1;
    tests_run++; if (bus.imem_req_addr !== 32'h1000) begin tests_failed++; $display("FAIL midreset_pc: got %h want 00001000", bus.imem_req_addr); end
    tests_run++; if (bus.imem_req_valid !== 1'b1) begin tests_failed++; $display("FAIL midreset_req_resume: got %b want 1", bus.imem_req_valid); end
    pc_write = 1'b0;
    cycle();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_full();
    test_branch_flush();
    test_priority();
    test_stall();
    test_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
